// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch core
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int   CS_MAX      = 99;
    localparam bcd_t CS_TENS_MAX = bcd_t'(CS_MAX / 10);
    localparam bcd_t CS_ONES_MAX = bcd_t'(CS_MAX % 10);
    localparam bcd_t DIGIT_MAX   = 4'd9;

    // Two-digit BCD of a binary value already known to be below 100.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
        bcd_t t;
        bcd_t o;
        t = bcd_t'(v / 7'd10);
        o = bcd_t'(v % 7'd10);
        return {t, o};
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// rtl/stopwatch_bcd_digit.sv - one BCD digit counter with up/down step and programmable max
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic [3:0] i_max,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_borrow
);

    bcd_t r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
        end else if (i_clr) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= i_load_val;
        end else if (i_inc) begin
            r_digit <= (r_digit >= i_max) ? 4'd0 : r_digit + 4'd1;
        end else if (i_dec) begin
            r_digit <= (r_digit == 4'd0) ? i_max : r_digit - 4'd1;
        end
    end

    // Carry/borrow are combinational so a whole chain ripples in one cycle.
    assign o_carry  = i_inc & (r_digit >= i_max);
    assign o_borrow = i_dec & (r_digit == 4'd0);
    assign o_digit  = r_digit;

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - SS.cc BCD stopwatch with up-count, countdown preset and done pulse
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       count_down,
    input  logic       load_en,
    input  logic [6:0] load_sec,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones,
    output logic       running,
    output logic       done
);

    localparam logic [6:0] MAX_SEC_B = 7'(MAX_SEC);
    localparam bcd_t       MAX_SEC_T = bcd_t'(MAX_SEC / 10);
    localparam bcd_t       MAX_SEC_O = bcd_t'(MAX_SEC % 10);

    sw_state_t r_state;
    sw_state_t w_state_nxt;
    logic      r_dir;
    logic      r_tick_q;
    logic      r_done;

    logic       w_tick_rise;
    logic       w_zero;
    logic       w_one;
    logic       w_at_max;
    logic       w_go;
    logic       w_step_up;
    logic       w_step_dn;
    logic       w_load;
    logic       w_clr_all;
    logic       w_done_nxt;
    logic [6:0] w_load_sat;
    logic [7:0] w_load_bcd;
    logic       w_c0, w_c1, w_c2, w_c3;
    logic       w_b0, w_b1, w_b2, w_b3;
    logic       w_unused_ovf;

    assign w_tick_rise = tick_in & ~r_tick_q;
    assign w_zero      = (sec_tens == 4'd0) && (sec_ones == 4'd0) &&
                         (cs_tens == 4'd0) && (cs_ones == 4'd0);
    assign w_one       = (sec_tens == 4'd0) && (sec_ones == 4'd0) &&
                         (cs_tens == 4'd0) && (cs_ones == 4'd1);
    assign w_at_max    = (sec_tens == MAX_SEC_T) && (sec_ones == MAX_SEC_O) &&
                         (cs_tens == CS_TENS_MAX) && (cs_ones == CS_ONES_MAX);
    // A countdown from 00.00 has nothing to do, so it never leaves IDLE.
    assign w_go        = start_stop & ~(count_down & w_zero);

    assign w_load_sat  = (load_sec > MAX_SEC_B) ? MAX_SEC_B : load_sec;
    assign w_load_bcd  = bin_to_bcd2(w_load_sat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_step_dn && w_one)  w_state_nxt = ST_IDLE;
                    else if (start_stop)     w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_stop) w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_step_up  = 1'b0;
        w_step_dn  = 1'b0;
        w_load     = 1'b0;
        w_clr_all  = clear;
        w_done_nxt = 1'b0;
        if (!clear) begin
            w_load    = (r_state == ST_IDLE) & load_en;
            w_step_up = (r_state == ST_RUN) & w_tick_rise & ~r_dir;
            w_step_dn = (r_state == ST_RUN) & w_tick_rise & r_dir & ~w_zero;
            // Wrap is a clear of all digits rather than a carry out of the seconds.
            w_clr_all  = w_step_up & w_at_max;
            w_done_nxt = (w_step_up & w_at_max) | (w_step_dn & w_one);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir    <= 1'b0;
            r_tick_q <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tick_q <= tick_in;
            r_done   <= w_done_nxt;
            if (clear) begin
                r_dir <= 1'b0;
            end else if ((r_state == ST_IDLE) && w_go) begin
                r_dir <= count_down;
            end
        end
    end

    bcd_digit u_cs_ones (
        .clk        (clk),
        .rst_n      (reset),
        .i_clr      (w_clr_all),
        .i_load     (w_load),
        .i_load_val (4'd0),
        .i_inc      (w_step_up),
        .i_dec      (w_step_dn),
        .i_max      (CS_ONES_MAX),
        .o_digit    (cs_ones),
        .o_carry    (w_c0),
        .o_borrow   (w_b0)
    );

    bcd_digit u_cs_tens (
        .clk        (clk),
        .rst_n      (reset),
        .i_clr      (w_clr_all),
        .i_load     (w_load),
        .i_load_val (4'd0),
        .i_inc      (w_c0),
        .i_dec      (w_b0),
        .i_max      (CS_TENS_MAX),
        .o_digit    (cs_tens),
        .o_carry    (w_c1),
        .o_borrow   (w_b1)
    );

    bcd_digit u_sec_ones (
        .clk        (clk),
        .rst_n      (reset),
        .i_clr      (w_clr_all),
        .i_load     (w_load),
        .i_load_val (w_load_bcd[3:0]),
        .i_inc      (w_c1),
        .i_dec      (w_b1),
        .i_max      (DIGIT_MAX),
        .o_digit    (sec_ones),
        .o_carry    (w_c2),
        .o_borrow   (w_b2)
    );

    bcd_digit u_sec_tens (
        .clk        (clk),
        .rst_n      (reset),
        .i_clr      (w_clr_all),
        .i_load     (w_load),
        .i_load_val (w_load_bcd[7:4]),
        .i_inc      (w_c2),
        .i_dec      (w_b2),
        .i_max      (DIGIT_MAX),
        .o_digit    (sec_tens),
        .o_carry    (w_c3),
        .o_borrow   (w_b3)
    );

    assign w_unused_ovf = w_c3 | w_b3;

    assign running = (r_state == ST_RUN);
    assign done    = r_done;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       count_down = 1'b0;
    logic       load_en = 1'b0;
    logic [6:0] load_sec = 7'd0;
    logic [3:0] sec_tens, sec_ones, cs_tens, cs_ones;
    logic       running, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_base;

    stopwatch_core #(.MAX_SEC(59)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .count_down (count_down),
        .load_en    (load_en),
        .load_sec   (load_sec),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .cs_tens    (cs_tens),
        .cs_ones    (cs_ones),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    function automatic logic [15:0] value();
        return {sec_tens, sec_ones, cs_tens, cs_ones};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
    endtask

    task automatic pulse_load(input logic [6:0] s);
        load_sec = s;
        load_en  = 1'b1;
        cyc();
        load_en  = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc();
            cyc();
            tick_in = 1'b0;
            cyc();
            cyc();
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset_value", 32'(value()), 32'h0000);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // up count 150 ticks, tick held high several cycles counts once
        done_base = done_cnt;
        pulse_ss();
        chk("up_running", 32'(running), 32'd1);
        tick_in = 1'b1;
        repeat (10) cyc();
        tick_in = 1'b0;
        cyc();
        chk("stuck_high_one_step", 32'(value()), 32'h0001);
        ticks(149);
        chk("up_150", 32'(value()), 32'h0150);
        chk("up_running_after", 32'(running), 32'd1);
        chk("up_no_done", 32'(done_cnt - done_base), 32'd0);

        // async reset mid-run at 12.34
        ticks(1084);
        chk("at_1234", 32'(value()), 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_value", 32'(value()), 32'h0000);
        chk("async_rst_running", 32'(running), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // wrap after 59.99
        done_base = done_cnt;
        pulse_ss();
        ticks(5999);
        chk("pre_wrap", 32'(value()), 32'h5999);
        chk("pre_wrap_no_done", 32'(done_cnt - done_base), 32'd0);
        tick_in = 1'b1;
        cyc();
        chk("wrap_value", 32'(value()), 32'h0000);
        chk("wrap_done_hi", 32'(done), 32'd1);
        chk("wrap_running", 32'(running), 32'd1);
        cyc();
        chk("wrap_done_lo", 32'(done), 32'd0);
        tick_in = 1'b0;
        cyc();
        cyc();
        chk("wrap_done_count", 32'(done_cnt - done_base), 32'd1);
        ticks(1);
        chk("post_wrap_step", 32'(value()), 32'h0001);

        // countdown
        pulse_clear();
        chk("clear_value", 32'(value()), 32'h0000);
        chk("clear_idle", 32'(running), 32'd0);
        done_base = done_cnt;
        count_down = 1'b1;
        pulse_ss();
        chk("cd_zero_stays_idle", 32'(running), 32'd0);
        pulse_load(7'd2);
        chk("load_2", 32'(value()), 32'h0200);
        pulse_ss();
        chk("cd_running", 32'(running), 32'd1);
        ticks(199);
        chk("cd_0001", 32'(value()), 32'h0001);
        tick_in = 1'b1;
        cyc();
        chk("cd_zero", 32'(value()), 32'h0000);
        chk("cd_done_hi", 32'(done), 32'd1);
        chk("cd_idle", 32'(running), 32'd0);
        cyc();
        chk("cd_done_lo", 32'(done), 32'd0);
        tick_in = 1'b0;
        cyc();
        cyc();
        ticks(3);
        chk("cd_floor", 32'(value()), 32'h0000);
        chk("cd_done_count", 32'(done_cnt - done_base), 32'd1);
        pulse_load(7'd75);
        chk("load_clamp", 32'(value()), 32'h5900);
        count_down = 1'b0;

        // pause / resume
        pulse_clear();
        pulse_ss();
        ticks(37);
        chk("pr_37", 32'(value()), 32'h0037);
        pulse_ss();
        chk("pr_paused", 32'(running), 32'd0);
        pulse_load(7'd10);
        chk("pr_load_ignored", 32'(value()), 32'h0037);
        ticks(20);
        chk("pr_frozen", 32'(value()), 32'h0037);
        pulse_ss();
        chk("pr_resumed", 32'(running), 32'd1);
        ticks(3);
        chk("pr_40", 32'(value()), 32'h0040);

        // clear + start_stop + tick_rise from RUN at 05.05
        ticks(465);
        chk("at_0505", 32'(value()), 32'h0505);
        done_base = done_cnt;
        clear = 1'b1;
        start_stop = 1'b1;
        tick_in = 1'b1;
        cyc();
        clear = 1'b0;
        start_stop = 1'b0;
        chk("simul_value", 32'(value()), 32'h0000);
        chk("simul_idle", 32'(running), 32'd0);
        cyc();
        tick_in = 1'b0;
        cyc();
        cyc();
        ticks(2);
        chk("simul_no_step_idle", 32'(value()), 32'h0000);
        chk("simul_no_done", 32'(done_cnt - done_base), 32'd0);

        // start_stop with tick_rise: in RUN step then pause, in PAUSE no step
        pulse_ss();
        start_stop = 1'b1;
        tick_in = 1'b1;
        cyc();
        start_stop = 1'b0;
        chk("run_ss_tick_step", 32'(value()), 32'h0001);
        chk("run_ss_tick_pause", 32'(running), 32'd0);
        cyc();
        tick_in = 1'b0;
        cyc();
        cyc();
        start_stop = 1'b1;
        tick_in = 1'b1;
        cyc();
        start_stop = 1'b0;
        chk("pause_ss_tick_nostep", 32'(value()), 32'h0001);
        chk("pause_ss_tick_run", 32'(running), 32'd1);
        cyc();
        tick_in = 1'b0;
        cyc();
        cyc();
        ticks(1);
        chk("resume_step", 32'(value()), 32'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
